// File: rtl/fetch_queue_pkg.sv
// Shared processor types for the instruction fetch path: address/code widths
// and the queued fetch entry.
package fetch_queue_pkg;

  localparam int unsigned PC_W      = 12;
  localparam int unsigned INSTR_W   = 9;
  localparam int unsigned DEPTH_DEF = 4;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } fetch_entry_t;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: ROM address/data, jump redirect and the dequeue handshake.
// master = ROM + consumer side, slave = the queue itself.
interface fetch_queue_if #(
  parameter int unsigned DEPTH   = fetch_queue_pkg::DEPTH_DEF,
  parameter int unsigned PC_W    = fetch_queue_pkg::PC_W,
  parameter int unsigned INSTR_W = fetch_queue_pkg::INSTR_W
);

  localparam int unsigned CNT_W = fetch_queue_pkg::cnt_width(DEPTH);

  logic [PC_W-1:0]    rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic               jump_en;
  logic [PC_W-1:0]    jump_target;
  logic               deq_ready;
  logic               deq_valid;
  logic [INSTR_W-1:0] deq_instr;
  logic [PC_W-1:0]    deq_pc;
  logic [CNT_W-1:0]   count;

  modport master (
    output rom_data, jump_en, jump_target, deq_ready,
    input  rom_addr, deq_valid, deq_instr, deq_pc, count
  );

  modport slave (
    input  rom_data, jump_en, jump_target, deq_ready,
    output rom_addr, deq_valid, deq_instr, deq_pc, count
  );

endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: walks a fetch pointer through the ROM, buffers
// {pc, code} in a circular register array and hands the head to the decoder.
module fetch_queue #(
  parameter int unsigned DEPTH   = fetch_queue_pkg::DEPTH_DEF,
  parameter int unsigned PC_W    = fetch_queue_pkg::PC_W,
  parameter int unsigned INSTR_W = fetch_queue_pkg::INSTR_W
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  bus
);

  import fetch_queue_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic [PC_W-1:0]  fpc_q, fpc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             deq_valid_q, deq_valid_d;
  fetch_entry_t     head_q, head_d;
  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];

  logic         pop;
  logic         push;
  logic         has_room;
  fetch_entry_t new_entry;

  // Next-state: push/pop bookkeeping, jump flush, and the registered head view.
  always_comb begin
    fpc_d     = fpc_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    mem_d     = mem_q;
    head_d    = '0;

    pop             = deq_valid_q & bus.deq_ready;
    has_room        = (count_q < CNT_W'(DEPTH)) | pop;
    push            = ~bus.jump_en & has_room;
    new_entry.pc    = pc_t'(fpc_q);
    new_entry.instr = instr_t'(bus.rom_data);

    if (bus.jump_en) begin
      // A pop in this cycle already consumed the head; everything else is dropped.
      fpc_d    = bus.jump_target;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        fpc_d           = fpc_q + PC_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    deq_valid_d = (count_d != '0);
    // mem_d already contains this cycle's write, so a just-pushed head is seen.
    if (deq_valid_d) begin
      head_d = mem_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      deq_valid_q <= 1'b0;
      head_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      fpc_q       <= fpc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      deq_valid_q <= deq_valid_d;
      head_q      <= head_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus.rom_addr  = fpc_q;
  assign bus.count     = count_q;
  assign bus.deq_valid = deq_valid_q;
  assign bus.deq_pc    = PC_W'(head_q.pc);
  assign bus.deq_instr = INSTR_W'(head_q.instr);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill, streaming, jumps, wrap and async reset.
module tb_fetch_queue;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  fetch_queue_if #(.DEPTH(4), .PC_W(12), .INSTR_W(9)) fq_if ();

  fetch_queue #(.DEPTH(4), .PC_W(12), .INSTR_W(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (fq_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] rom_fn(input logic [11:0] a);
    return a[8:0] ^ a[11:3] ^ 9'h0A5;
  endfunction

  always_comb fq_if.rom_data = rom_fn(fq_if.rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] wrap_pcs [4];
    wrap_pcs[0] = 12'hFFE;
    wrap_pcs[1] = 12'hFFF;
    wrap_pcs[2] = 12'h000;
    wrap_pcs[3] = 12'h001;
    n_cmp = 0;
    n_err = 0;
    reset             = 1'b1;
    fq_if.jump_en     = 1'b0;
    fq_if.jump_target = '0;
    fq_if.deq_ready   = 1'b0;

    // reset state
    repeat (2) tick;
    chk("rst_count", 32'(fq_if.count), 32'd0);
    chk("rst_valid", 32'(fq_if.deq_valid), 32'd0);
    chk("rst_rom_addr", 32'(fq_if.rom_addr), 32'd0);
    chk("rst_deq_pc", 32'(fq_if.deq_pc), 32'd0);
    chk("rst_deq_instr", 32'(fq_if.deq_instr), 32'd0);

    // fill after reset release
    @(negedge clk);
    reset = 1'b0;
    tick;
    chk("fill1_count", 32'(fq_if.count), 32'd1);
    chk("fill1_valid", 32'(fq_if.deq_valid), 32'd1);
    chk("fill1_pc", 32'(fq_if.deq_pc), 32'd0);
    chk("fill1_rom_addr", 32'(fq_if.rom_addr), 32'd1);
    repeat (3) tick;
    chk("fill4_count", 32'(fq_if.count), 32'd4);
    chk("fill4_rom_addr", 32'(fq_if.rom_addr), 32'd4);
    chk("fill4_pc", 32'(fq_if.deq_pc), 32'd0);
    chk("fill4_instr", 32'(fq_if.deq_instr), 32'(rom_fn(12'h000)));
    tick;
    chk("full_hold_count", 32'(fq_if.count), 32'd4);
    chk("full_hold_rom_addr", 32'(fq_if.rom_addr), 32'd4);

    // streaming at full occupancy
    fq_if.deq_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      chk("stream_pc", 32'(fq_if.deq_pc), 32'(k));
      chk("stream_count", 32'(fq_if.count), 32'd4);
      chk("stream_rom_addr", 32'(fq_if.rom_addr), 32'(4 + k));
    end
    chk("stream_instr", 32'(fq_if.deq_instr), 32'(rom_fn(12'h006)));

    // jump from a full queue, refill to three
    fq_if.deq_ready   = 1'b0;
    fq_if.jump_en     = 1'b1;
    fq_if.jump_target = 12'h050;
    tick;
    chk("j50_count", 32'(fq_if.count), 32'd0);
    chk("j50_valid", 32'(fq_if.deq_valid), 32'd0);
    chk("j50_rom_addr", 32'(fq_if.rom_addr), 32'h050);
    fq_if.jump_en = 1'b0;
    repeat (3) tick;
    chk("j50_fill_count", 32'(fq_if.count), 32'd3);
    chk("j50_fill_pc", 32'(fq_if.deq_pc), 32'h050);
    chk("j50_fill_rom_addr", 32'(fq_if.rom_addr), 32'h053);

    // jump with count=3 to 0x100
    fq_if.jump_en     = 1'b1;
    fq_if.jump_target = 12'h100;
    tick;
    chk("j100_count", 32'(fq_if.count), 32'd0);
    chk("j100_valid", 32'(fq_if.deq_valid), 32'd0);
    chk("j100_empty_pc", 32'(fq_if.deq_pc), 32'd0);
    chk("j100_empty_instr", 32'(fq_if.deq_instr), 32'd0);
    fq_if.jump_en = 1'b0;
    tick;
    chk("j100_next_count", 32'(fq_if.count), 32'd1);
    chk("j100_next_valid", 32'(fq_if.deq_valid), 32'd1);
    chk("j100_next_pc", 32'(fq_if.deq_pc), 32'h100);
    chk("j100_next_rom_addr", 32'(fq_if.rom_addr), 32'h101);
    chk("j100_next_instr", 32'(fq_if.deq_instr), 32'(rom_fn(12'h100)));

    // jump near the top of the address space: fpc wraps
    fq_if.jump_en     = 1'b1;
    fq_if.jump_target = 12'hFFE;
    tick;
    fq_if.jump_en = 1'b0;
    repeat (4) tick;
    chk("wrap_count", 32'(fq_if.count), 32'd4);
    chk("wrap_rom_addr", 32'(fq_if.rom_addr), 32'h002);
    fq_if.deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_pc", 32'(fq_if.deq_pc), 32'(wrap_pcs[i]));
      chk("wrap_instr", 32'(fq_if.deq_instr), 32'(rom_fn(wrap_pcs[i])));
      tick;
    end
    chk("wrap_after_pc", 32'(fq_if.deq_pc), 32'h002);

    // jump and pop in the same cycle, head pc=5
    fq_if.deq_ready   = 1'b0;
    fq_if.jump_en     = 1'b1;
    fq_if.jump_target = 12'h005;
    tick;
    fq_if.jump_en = 1'b0;
    repeat (3) tick;
    chk("jp_pre_count", 32'(fq_if.count), 32'd3);
    chk("jp_pre_pc", 32'(fq_if.deq_pc), 32'h005);
    fq_if.jump_en     = 1'b1;
    fq_if.jump_target = 12'h200;
    fq_if.deq_ready   = 1'b1;
    tick;
    chk("jp_count", 32'(fq_if.count), 32'd0);
    chk("jp_valid", 32'(fq_if.deq_valid), 32'd0);
    fq_if.jump_en = 1'b0;
    tick;
    chk("jp_head_pc", 32'(fq_if.deq_pc), 32'h200);
    chk("jp_head_count", 32'(fq_if.count), 32'd1);
    tick;
    chk("jp_next_pc", 32'(fq_if.deq_pc), 32'h201);
    chk("jp_next_count", 32'(fq_if.count), 32'd1);

    // asynchronous reset mid-cycle with count=3
    fq_if.deq_ready   = 1'b0;
    fq_if.jump_en     = 1'b1;
    fq_if.jump_target = 12'h030;
    tick;
    fq_if.jump_en = 1'b0;
    repeat (3) tick;
    chk("arst_pre_count", 32'(fq_if.count), 32'd3);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_count", 32'(fq_if.count), 32'd0);
    chk("arst_valid", 32'(fq_if.deq_valid), 32'd0);
    chk("arst_rom_addr", 32'(fq_if.rom_addr), 32'd0);
    chk("arst_deq_pc", 32'(fq_if.deq_pc), 32'd0);
    fq_if.jump_en     = 1'b1;
    fq_if.jump_target = 12'h777;
    fq_if.deq_ready   = 1'b1;
    repeat (2) tick;
    chk("arst_hold_count", 32'(fq_if.count), 32'd0);
    chk("arst_hold_rom_addr", 32'(fq_if.rom_addr), 32'd0);
    @(negedge clk);
    reset           = 1'b0;
    fq_if.jump_en   = 1'b0;
    fq_if.deq_ready = 1'b0;
    tick;
    chk("arst_rel_count", 32'(fq_if.count), 32'd1);
    chk("arst_rel_pc", 32'(fq_if.deq_pc), 32'd0);
    chk("arst_rel_rom_addr", 32'(fq_if.rom_addr), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of two, 2..8).
REQ-002 SHALL have parameter PC_W, default 12, meaning the program-counter width.
REQ-003 SHALL have parameter INSTR_W, default 9, meaning the machine-code width.
REQ-004 SHALL have port clk  input  1  system clock, rising-edge.
REQ-005 SHALL have port reset  input  1  reset; one clock, reset is asynchronous and active-high.
REQ-006 SHALL have port rom_addr  output  PC_W  fetch address to the instruction ROM.
REQ-007 SHALL have port rom_data  input  INSTR_W  machine code returned combinationally for rom_addr.
REQ-008 SHALL have port jump_en  input  1  redirect fetch to jump_target.
REQ-009 SHALL have port jump_target  input  PC_W  redirect address.
REQ-010 SHALL have port deq_ready  input  1  consumer accepts the head entry.
REQ-011 SHALL have port deq_valid  output  1  head entry is valid.
REQ-012 SHALL have port deq_instr  output  INSTR_W  head machine code.
REQ-013 SHALL have port deq_pc  output  PC_W  address of the head instruction.
REQ-014 SHALL have port count  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-015 SHALL hold a fetch pointer fpc and drive rom_addr = fpc.
REQ-016 SHALL push {fpc, rom_data} at the clock edge when jump_en=0 and the queue has room, then set fpc = fpc+1.
REQ-017 SHALL treat the queue as having room when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
REQ-018 SHALL hold fpc and push nothing when full and not popping.
REQ-019 SHALL pop the head at the edge when deq_valid=1 and deq_ready=1; deq_ready SHALL be ignored while empty.
REQ-020 SHALL drive deq_valid = (count!=0) and present the head entry from registered storage, so a pushed entry is visible the cycle after its push.
REQ-021 SHALL drive deq_instr=0 and deq_pc=0 while empty.
REQ-022 SHALL update count by +1 for push only, -1 for pop only, and 0 for both or neither.
REQ-023 SHALL wrap fpc modulo 2^PC_W, so 0xFFF+1=0x000.
REQ-024 SHALL, on jump_en=1, at the next edge discard all entries, set count=0, set fpc=jump_target, and suppress the push.
REQ-025 SHALL treat a pop handshake in the jump cycle as a normal consumption of the head entry, then discard the remainder.
REQ-026 SHALL, after a jump, push the target at the first edge after the jump edge and assert deq_valid with deq_pc=jump_target one cycle later.
REQ-027 SHALL never emit entries out of address order except across a jump.

Reset
REQ-028 SHALL, while reset=1, asynchronously force fpc=0, count=0, read/write pointers=0, deq_valid=0, deq_instr=0, deq_pc=0, and rom_addr=0.
REQ-029 SHALL ignore jump_en, deq_ready, and pushes while reset=1; the first push (pc 0) SHALL occur at the first edge after deassertion.

Structure
REQ-030 SHALL take PC_W=12 and INSTR_W=9 from the shared processor package, together with typedef fetch_entry_t {pc, instr}.
REQ-031 SHALL implement storage as an inline circular register array of fetch_entry_t with pointers of width $clog2(DEPTH); no sub-module is needed.
REQ-032 SHALL be instantiated between instr_ROM and control, feeding deq_instr as the decoder's mach_code.

Verification
REQ-033 Reset release, deq_ready=0 -> pushes pc 0..3 on four edges, count=4, rom_addr held at 4, deq_valid=1, deq_pc=0.
REQ-034 Full queue, deq_ready=1 constantly -> deq_pc 0,1,2,3,4,... one per cycle, count stays 4.
REQ-035 count=3, jump_en=1 with target 0x100 -> next cycle count=0 and deq_valid=0; one cycle later deq_pc=0x100 and rom_addr=0x101.
REQ-036 Jump to 0xFFE, deq_ready=0 -> entries pc 0xFFE, 0xFFF, 0x000, 0x001 in order.
REQ-037 Jump and pop in the same cycle with head pc=5 -> pc 5 consumed once, pc 6 and 7 never appear, next head = target.
REQ-038 reset asserted mid-cycle with count=3 -> deq_valid=0, count=0, and rom_addr=0 immediately, without a clock edge.
